exwb_pipe_reg: RTL and testbench
================================

// Module: exwb_pipe_reg
// PURPOSE
// - EX/WB pipeline register of the Banff core; takes the operand-selected execute payload and presents it to writeback.
// - Two-entry skid buffer with valid/ready on both sides: full throughput, no combinational ready path upstream.
// - Supports pipeline flush and a saturating writeback-stall counter.
// PARAMETERS
// - XLEN         32  datapath / PC width
// - REG_ADDR_W    5  register-file address width
// - CAUSE_W       4  exception cause width
// - STALL_CNT_W  16  stall counter width
// PORTS
// - clock        in   1           single core clock; all state on posedge
// - reset        in   1           asynchronous, active-low reset
// - flush        in   1           synchronous kill of all held entries
// - ex_valid     in   1           execute payload valid
// - ex_ready     out  1           buffer can accept (registered)
// - ex_result    in   XLEN        result value
// - ex_rd        in   REG_ADDR_W  destination register
// - ex_rd_we     in   1           register write request
// - ex_pc        in   XLEN        instruction PC
// - ex_exc       in   1           exception flag
// - ex_exc_cause in   CAUSE_W     exception cause
// - wb_valid     out  1           writeback payload valid
// - wb_ready     in   1           writeback accepts
// - wb_result/wb_rd/wb_rd_we/wb_pc/wb_exc/wb_exc_cause  out  as ex_*  held payload
// - stall_cnt    out  STALL_CNT_W cycles with wb_valid & !wb_ready, saturating
// BEHAVIOUR
// - ex_fire = ex_valid & ex_ready; wb_fire = wb_valid & wb_ready.
// - States: EMPTY (0 entries), ONE (main slot), FULL (main + skid). Outputs always driven from main slot.
// - EMPTY: ex_fire -> ONE, main<=ex.
// - ONE: ex_fire&wb_fire -> ONE, main<=ex; ex_fire&!wb_fire -> FULL, skid<=ex; !ex_fire&wb_fire -> EMPTY.
// - FULL: wb_fire -> ONE, main<=skid; no ex_fire possible.
// - ex_ready = (next_state != FULL), registered; wb_valid = (state != EMPTY), registered.
// - Latency: entry accepted cycle N is on wb_* in cycle N+1 if main slot free.
// - Payload held stable while wb_valid & !wb_ready; order strictly FIFO.
// - Capture rule: stored rd_we = ex_rd_we & (ex_rd != 0) & !ex_exc.
// - flush=1: next state EMPTY, any ex_fire that cycle discarded, wb_fire that cycle still counts; ex_ready=1 next cycle.
// - stall_cnt increments when wb_valid & !wb_ready; holds at all-ones; cleared only by reset.
// - Reset (async, reset=0): state EMPTY, wb_valid 0, ex_ready 1, all payload regs 0, stall_cnt 0.
//   Reset mid-transfer drops all held entries; deassertion is synchronised externally.
// CONFIGURATION
// - Macro EXWB_FWD_EN defined: adds outputs fwd0_valid/fwd0_rd/fwd0_data (main slot) and
//   fwd1_valid/fwd1_rd/fwd1_data (skid slot); fwdN_valid = slot occupied & stored rd_we; combinational from regs.
//   fwd1 is the younger entry and has priority at the consumer.
// - Undefined: no forwarding ports, no extra logic; all other behaviour identical.
// STRUCTURE
// - banff_core_pkg: XLEN, REG_ADDR_W, CAUSE_W defaults, EXWB state encodings (EMPTY=2'd0, ONE=2'd1, FULL=2'd2),
//   EXWB payload width constant / packed field offsets.
// - One sub-module: exwb_slot_reg (payload register, load enable, async active-low reset), instanced for main and skid.
// TESTING
// - Reset then 8 back-to-back ex_valid with wb_ready=1 -> wb_valid from cycle 1, 8 payloads in order, ex_ready stays 1.
// - wb_ready=0, send A,B -> ex_ready=0 after B; wb_* holds A; raise wb_ready -> A then B, ex_ready=1 again.
// - ex_rd=0, ex_rd_we=1, result 0xDEADBEEF -> wb_rd_we=0, wb_result=0xDEADBEEF.
// - FULL state, assert flush with ex_valid=1 -> next cycle wb_valid=0, ex_ready=1, no entry leaks.
// - wb_ready=0 for 70000 cycles with entry held -> stall_cnt saturates at 0xFFFF.
// - EXWB_FWD_EN: FULL with A(rd=3), B(rd=3) -> fwd0_rd=3 data A, fwd1_rd=3 data B, both valid.

Source files
------------

// File: rtl/banff_core_pkg.sv
// Banff core shared constants: default widths, EX/WB skid-buffer state encodings
// and the packed EX/WB payload layout {result, rd, rd_we, pc, exc, exc_cause}.
`timescale 1ns/1ps
package banff_core_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int CAUSE_W_DEF    = 4;

  localparam logic [1:0] EXWB_EMPTY = 2'd0;
  localparam logic [1:0] EXWB_ONE   = 2'd1;
  localparam logic [1:0] EXWB_FULL  = 2'd2;

  // Field offsets, LSB first; exc_cause sits at bit 0.
  function automatic int exwb_off_exc(int cause_w);
    return cause_w;
  endfunction

  function automatic int exwb_off_pc(int cause_w);
    return cause_w + 1;
  endfunction

  function automatic int exwb_off_rd_we(int xlen, int cause_w);
    return cause_w + 1 + xlen;
  endfunction

  function automatic int exwb_off_rd(int xlen, int cause_w);
    return cause_w + 2 + xlen;
  endfunction

  function automatic int exwb_off_result(int xlen, int reg_addr_w, int cause_w);
    return cause_w + 2 + xlen + reg_addr_w;
  endfunction

  function automatic int exwb_payload_w(int xlen, int reg_addr_w, int cause_w);
    return cause_w + 2 + 2 * xlen + reg_addr_w;
  endfunction

  localparam int EXWB_PAYLOAD_W = exwb_payload_w(XLEN_DEF, REG_ADDR_W_DEF, CAUSE_W_DEF);

endpackage

// File: rtl/exwb_slot_reg.sv
// One EX/WB payload slot: load-enabled register, cleared by the async active-low reset.
`timescale 1ns/1ps
module exwb_slot_reg
  import banff_core_pkg::*;
#(
  parameter int W = EXWB_PAYLOAD_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exwb_pipe_reg.sv
// Banff EX/WB pipeline register: two-entry skid buffer with registered ready/valid,
// flush and a saturating writeback-stall counter. Define EXWB_FWD_EN for forwarding ports.
`timescale 1ns/1ps
module exwb_pipe_reg
  import banff_core_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int CAUSE_W     = CAUSE_W_DEF,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic [XLEN-1:0]        ex_result,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_rd_we,
  input  logic [XLEN-1:0]        ex_pc,
  input  logic                   ex_exc,
  input  logic [CAUSE_W-1:0]     ex_exc_cause,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [XLEN-1:0]        wb_result,
  output logic [REG_ADDR_W-1:0]  wb_rd,
  output logic                   wb_rd_we,
  output logic [XLEN-1:0]        wb_pc,
  output logic                   wb_exc,
  output logic [CAUSE_W-1:0]     wb_exc_cause,
  output logic [STALL_CNT_W-1:0] stall_cnt
`ifdef EXWB_FWD_EN
  ,
  output logic                   fwd0_valid,
  output logic [REG_ADDR_W-1:0]  fwd0_rd,
  output logic [XLEN-1:0]        fwd0_data,
  output logic                   fwd1_valid,
  output logic [REG_ADDR_W-1:0]  fwd1_rd,
  output logic [XLEN-1:0]        fwd1_data
`endif
);

  localparam int PW         = exwb_payload_w(XLEN, REG_ADDR_W, CAUSE_W);
  localparam int OFF_EXC    = exwb_off_exc(CAUSE_W);
  localparam int OFF_PC     = exwb_off_pc(CAUSE_W);
  localparam int OFF_RD_WE  = exwb_off_rd_we(XLEN, CAUSE_W);
  localparam int OFF_RD     = exwb_off_rd(XLEN, CAUSE_W);
  localparam int OFF_RESULT = exwb_off_result(XLEN, REG_ADDR_W, CAUSE_W);

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic          ex_fire;
  logic          wb_fire;
  logic          load_main;
  logic          load_skid;
  logic          main_from_skid;
  logic          ex_rd_we_eff;
  logic [PW-1:0] ex_payload;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;

  assign ex_fire = ex_valid & ex_ready;
  assign wb_fire = wb_valid & wb_ready;

  // Writes to x0 and from faulting instructions never reach the register file.
  assign ex_rd_we_eff = ex_rd_we & (ex_rd != '0) & ~ex_exc;
  assign ex_payload   = {ex_result, ex_rd, ex_rd_we_eff, ex_pc, ex_exc, ex_exc_cause};

  always_comb begin
    next_state     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EXWB_EMPTY: begin
        if (ex_fire) begin
          next_state = EXWB_ONE;
          load_main  = 1'b1;
        end
      end
      EXWB_ONE: begin
        if (ex_fire && wb_fire) begin
          load_main = 1'b1;
        end else if (ex_fire) begin
          next_state = EXWB_FULL;
          load_skid  = 1'b1;
        end else if (wb_fire) begin
          next_state = EXWB_EMPTY;
        end
      end
      EXWB_FULL: begin
        if (wb_fire) begin
          next_state     = EXWB_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: next_state = EXWB_EMPTY;
    endcase
    // Flush drops everything held plus anything accepted this cycle.
    if (flush) begin
      next_state = EXWB_EMPTY;
      load_main  = 1'b0;
      load_skid  = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : ex_payload;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= EXWB_EMPTY;
      ex_ready <= 1'b1;
      wb_valid <= 1'b0;
    end else begin
      state    <= next_state;
      ex_ready <= (next_state != EXWB_FULL);
      wb_valid <= (next_state != EXWB_EMPTY);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (wb_valid && !wb_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  exwb_slot_reg #(.W(PW)) u_main (
    .clock (clock),
    .reset (reset),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  exwb_slot_reg #(.W(PW)) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (load_skid),
    .d     (ex_payload),
    .q     (skid_q)
  );

  assign wb_exc_cause = main_q[CAUSE_W-1:0];
  assign wb_exc       = main_q[OFF_EXC];
  assign wb_pc        = main_q[OFF_PC +: XLEN];
  assign wb_rd_we     = main_q[OFF_RD_WE];
  assign wb_rd        = main_q[OFF_RD +: REG_ADDR_W];
  assign wb_result    = main_q[OFF_RESULT +: XLEN];

`ifdef EXWB_FWD_EN
  // Skid slot holds the younger entry, so fwd1 wins at the consumer.
  assign fwd0_valid = (state != EXWB_EMPTY) & main_q[OFF_RD_WE];
  assign fwd0_rd    = main_q[OFF_RD +: REG_ADDR_W];
  assign fwd0_data  = main_q[OFF_RESULT +: XLEN];
  assign fwd1_valid = (state == EXWB_FULL) & skid_q[OFF_RD_WE];
  assign fwd1_rd    = skid_q[OFF_RD +: REG_ADDR_W];
  assign fwd1_data  = skid_q[OFF_RESULT +: XLEN];
`endif

endmodule

// File: tb/tb_exwb_pipe_reg.sv
// Testbench for exwb_pipe_reg: scoreboard on the writeback side plus per-scenario checks.
`timescale 1ns/1ps
module tb_exwb_pipe_reg;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] pc;
    logic        exc;
    logic [3:0]  cause;
  } pl_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_result = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_rd_we = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_exc = 1'b0;
  logic [3:0]  ex_exc_cause = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_rd_we;
  logic [31:0] wb_pc;
  logic        wb_exc;
  logic [3:0]  wb_exc_cause;
  logic [15:0] stall_cnt;
`ifdef EXWB_FWD_EN
  logic        fwd0_valid, fwd1_valid;
  logic [4:0]  fwd0_rd, fwd1_rd;
  logic [31:0] fwd0_data, fwd1_data;
`endif

  int  checks = 0;
  int  errors = 0;
  pl_t sb[$];

  exwb_pipe_reg dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_result    (ex_result),
    .ex_rd        (ex_rd),
    .ex_rd_we     (ex_rd_we),
    .ex_pc        (ex_pc),
    .ex_exc       (ex_exc),
    .ex_exc_cause (ex_exc_cause),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_result    (wb_result),
    .wb_rd        (wb_rd),
    .wb_rd_we     (wb_rd_we),
    .wb_pc        (wb_pc),
    .wb_exc       (wb_exc),
    .wb_exc_cause (wb_exc_cause),
    .stall_cnt    (stall_cnt)
`ifdef EXWB_FWD_EN
    ,
    .fwd0_valid   (fwd0_valid),
    .fwd0_rd      (fwd0_rd),
    .fwd0_data    (fwd0_data),
    .fwd1_valid   (fwd1_valid),
    .fwd1_rd      (fwd1_rd),
    .fwd1_data    (fwd1_data)
`endif
  );

  always #5 clock = ~clock;

  // Scoreboard, sampled on the falling edge while inputs and outputs are stable.
  always @(negedge clock) begin
    pl_t got;
    pl_t exp_pl;
    if (!reset) begin
      sb.delete();
    end else begin
      checks++;
      if (wb_valid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL sb_valid: wb_valid=%b expected %b (queued %0d)", wb_valid, sb.size() != 0, sb.size());
      end
      if (wb_valid === 1'b1 && sb.size() != 0) begin
        got = {wb_result, wb_rd, wb_rd_we, wb_pc, wb_exc, wb_exc_cause};
        checks++;
        if (got !== sb[0]) begin
          errors++;
          $display("FAIL sb_payload: got %h expected %h", got, sb[0]);
        end
      end
      if (wb_valid === 1'b1 && wb_ready && sb.size() != 0) void'(sb.pop_front());
      if (flush) begin
        sb.delete();
      end else if (ex_valid && ex_ready === 1'b1) begin
        exp_pl.result = ex_result;
        exp_pl.rd     = ex_rd;
        exp_pl.rd_we  = ex_rd_we && (ex_rd != 5'd0) && !ex_exc;
        exp_pl.pc     = ex_pc;
        exp_pl.exc    = ex_exc;
        exp_pl.cause  = ex_exc_cause;
        sb.push_back(exp_pl);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] res, input logic [4:0] rd,
                        input logic we, input logic [31:0] pc, input logic exc,
                        input logic [3:0] cause);
    ex_valid     = v;
    ex_result    = res;
    ex_rd        = rd;
    ex_rd_we     = we;
    ex_pc        = pc;
    ex_exc       = exc;
    ex_exc_cause = cause;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %b expected 1", ex_ready); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall: got %h expected 0", stall_cnt); end
    checks++; if ({wb_result, wb_rd, wb_rd_we, wb_pc} !== 70'h0) begin
      errors++; $display("FAIL reset_payload: got %h/%h/%b/%h expected zeros", wb_result, wb_rd, wb_rd_we, wb_pc);
    end
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_ex(1'b1, $urandom, 5'(i * 7), 1'b1, 32'h1000 + 32'(4 * i), (i == 5), 4'(i));
      tick();
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_wb_valid[%0d]: got %b expected 1", i, wb_valid); end
      checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_ex_ready[%0d]: got %b expected 1", i, ex_ready); end
    end
    set_ex(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: wb_valid got %b expected 0", wb_valid); end
  endtask

  task automatic test_skid();
    wb_ready = 1'b0;
    set_ex(1'b1, 32'hA0A0_0001, 5'd1, 1'b1, 32'h200, 1'b0, 4'h0);
    tick();
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_a: got %b expected 1", ex_ready); end
    set_ex(1'b1, 32'hB0B0_0002, 5'd2, 1'b1, 32'h204, 1'b0, 4'h0);
    tick();
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_full: got %b expected 0", ex_ready); end
    checks++; if (wb_result !== 32'hA0A0_0001) begin errors++; $display("FAIL skid_hold_a: got %h expected a0a00001", wb_result); end
    set_ex(1'b1, 32'hC0C0_0003, 5'd3, 1'b1, 32'h208, 1'b0, 4'h0);
    tick();
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_hold: got %b expected 0", ex_ready); end
    checks++; if (wb_result !== 32'hA0A0_0001) begin errors++; $display("FAIL skid_hold_a2: got %h expected a0a00001", wb_result); end
    set_ex(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    wb_ready = 1'b1;
    tick();
    checks++; if (wb_result !== 32'hB0B0_0002) begin errors++; $display("FAIL skid_then_b: got %h expected b0b00002", wb_result); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back: got %b expected 1", ex_ready); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL skid_empty: wb_valid got %b expected 0", wb_valid); end
  endtask

  task automatic test_rd_we_rule();
    wb_ready = 1'b0;
    set_ex(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'h300, 1'b0, 4'h0);
    tick();
    checks++; if (wb_rd_we !== 1'b0) begin errors++; $display("FAIL x0_rd_we: got %b expected 0", wb_rd_we); end
    checks++; if (wb_result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL x0_result: got %h expected deadbeef", wb_result); end
    wb_ready = 1'b1;
    set_ex(1'b1, 32'h1234_5678, 5'd5, 1'b1, 32'h304, 1'b1, 4'h7);
    tick();
    checks++; if ({wb_exc, wb_rd_we} !== 2'b10) begin errors++; $display("FAIL exc_rd_we: exc/rd_we got %b%b expected 10", wb_exc, wb_rd_we); end
    set_ex(1'b1, 32'h0BAD_F00D, 5'd7, 1'b1, 32'h308, 1'b0, 4'h0);
    tick();
    checks++; if ({wb_rd, wb_rd_we} !== {5'd7, 1'b1}) begin errors++; $display("FAIL rd7_we: rd/we got %0d/%b expected 7/1", wb_rd, wb_rd_we); end
    set_ex(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    tick();
  endtask

  task automatic test_flush();
    wb_ready = 1'b0;
    set_ex(1'b1, 32'h0000_00A1, 5'd1, 1'b1, 32'h400, 1'b0, 4'h0); tick();
    set_ex(1'b1, 32'h0000_00B2, 5'd2, 1'b1, 32'h404, 1'b0, 4'h0); tick();
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full: ex_ready got %b expected 0", ex_ready); end
    set_ex(1'b1, 32'h0000_00C3, 5'd3, 1'b1, 32'h408, 1'b0, 4'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid: got %b expected 0", wb_valid); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL flush_full_ready: got %b expected 1", ex_ready); end
    set_ex(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: wb_valid got %b expected 0", wb_valid); end
    // Flush in ONE with simultaneous accept and writeback fire.
    set_ex(1'b1, 32'h0000_00D4, 5'd4, 1'b1, 32'h40C, 1'b0, 4'h0); tick();
    wb_ready = 1'b1;
    set_ex(1'b1, 32'h0000_00E5, 5'd5, 1'b1, 32'h410, 1'b0, 4'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_ex(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    checks++; if ({wb_valid, ex_ready} !== 2'b01) begin errors++; $display("FAIL flush_one: valid/ready got %b%b expected 01", wb_valid, ex_ready); end
    tick();
  endtask

`ifdef EXWB_FWD_EN
  task automatic test_fwd();
    wb_ready = 1'b0;
    set_ex(1'b1, 32'h1111_1111, 5'd3, 1'b1, 32'h500, 1'b0, 4'h0); tick();
    set_ex(1'b1, 32'h2222_2222, 5'd3, 1'b1, 32'h504, 1'b0, 4'h0); tick();
    set_ex(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    checks++; if ({fwd0_valid, fwd0_rd, fwd0_data} !== {1'b1, 5'd3, 32'h1111_1111}) begin
      errors++; $display("FAIL fwd0: got %b/%0d/%h expected 1/3/11111111", fwd0_valid, fwd0_rd, fwd0_data);
    end
    checks++; if ({fwd1_valid, fwd1_rd, fwd1_data} !== {1'b1, 5'd3, 32'h2222_2222}) begin
      errors++; $display("FAIL fwd1: got %b/%0d/%h expected 1/3/22222222", fwd1_valid, fwd1_rd, fwd1_data);
    end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if ({fwd0_valid, fwd1_valid} !== 2'b00) begin
      errors++; $display("FAIL fwd_flush: got %b%b expected 00", fwd0_valid, fwd1_valid);
    end
  endtask
`endif

  task automatic test_stall_sat();
    wb_ready = 1'b0;
    set_ex(1'b1, 32'h0000_0F0F, 5'd9, 1'b1, 32'h600, 1'b0, 4'h0); tick();
    set_ex(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    #2 reset = 1'b0;
    #1;
    checks++; if ({wb_valid, ex_ready} !== 2'b01) begin errors++; $display("FAIL midreset: valid/ready got %b%b expected 01", wb_valid, ex_ready); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL midreset_stall: got %h expected 0", stall_cnt); end
    tick();
    reset = 1'b1;
    set_ex(1'b1, 32'h0000_1234, 5'd10, 1'b1, 32'h604, 1'b0, 4'h0); tick();
    set_ex(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL stall_start: got %h expected 0", stall_cnt); end
    repeat (10) tick();
    checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL stall_count10: got %0d expected 10", stall_cnt); end
    repeat (70000) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat: got %h expected ffff", stall_cnt); end
    tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat_hold: got %h expected ffff", stall_cnt); end
    wb_ready = 1'b1;
    tick();
    checks++; if ({wb_valid, stall_cnt} !== {1'b0, 16'hFFFF}) begin
      errors++; $display("FAIL stall_release: valid/cnt got %b/%h expected 0/ffff", wb_valid, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_skid();
    test_rd_we_rule();
    test_flush();
`ifdef EXWB_FWD_EN
    test_fwd();
`endif
    test_stall_sat();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
